chip_drop_animator: RTL and testbench

Sequences the falling-chip animation for the Connect Four board and commits the chip to the game state when it lands. Sits between the game FSM and the VGA display: accepts a drop request (column, player), computes the landing row from the current board, steps `anim_row` from the top row down to the landing row paced by `frame_tick`, and then issues a one-cycle commit pulse that the board registers use to set the occupancy bit.

---
 rtl/connect4_pkg.sv | 29 ++
 rtl/landing_row_finder.sv | 40 ++++
 rtl/chip_drop_animator.sv | 218 +++++++++++++++++++++
 tb/tb_chip_drop_animator.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/connect4_pkg.sv
// Shared Connect Four board geometry, cell indexing and drop-animation states.
//   ROWS/COLS   : board dimensions (row 0 is the bottom row)
//   idx()       : flat occupancy bit index for (row, col) = row*7 + col
//   drop_state_t: states of the chip-drop sequencer
package connect4_pkg;

    localparam int unsigned ROWS  = 6;
    localparam int unsigned COLS  = 7;
    localparam int unsigned CELLS = ROWS * COLS;
    localparam int unsigned ROW_W = 3;
    localparam int unsigned COL_W = 3;
    localparam int unsigned IDX_W = 6;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_FALL   = 3'd2,
        ST_BOUNCE = 3'd3,
        ST_SETTLE = 3'd4,
        ST_COMMIT = 3'd5
    } drop_state_t;

    function automatic logic [IDX_W-1:0] idx(input logic [ROW_W-1:0] row,
                                             input logic [COL_W-1:0] col);
        return IDX_W'(32'(row) * 32'(COLS) + 32'(col));
    endfunction

endpackage

// File: rtl/landing_row_finder.sv
// Combinational landing-row lookup for one column of the board.
//   occupancy_i : 42-bit combined occupancy (both players), bit = row*7 + col
//   col_i       : column to probe (values above 6 are treated as full)
//   land_row_o  : lowest empty row in the column (0 when the column is full)
//   full_o      : column has no empty cell, or column is out of range
module landing_row_finder
    import connect4_pkg::*;
(
    input  logic [CELLS-1:0] occupancy_i,
    input  logic [COL_W-1:0] col_i,
    output logic [ROW_W-1:0] land_row_o,
    output logic             full_o
);

    logic [ROWS-1:0] col_bits;

    // Gather the column's cells; an out-of-range column reads as all occupied.
    always_comb begin
        col_bits = '1;
        for (int c = 0; c < int'(COLS); c++) begin
            if (col_i == COL_W'(c)) begin
                for (int r = 0; r < int'(ROWS); r++) begin
                    col_bits[r] = occupancy_i[idx(ROW_W'(r), COL_W'(c))];
                end
            end
        end
    end

    // Scan top-down so the lowest clear row wins.
    always_comb begin
        land_row_o = '0;
        for (int r = int'(ROWS) - 1; r >= 0; r--) begin
            if (!col_bits[r]) begin
                land_row_o = ROW_W'(r);
            end
        end
        full_o = &col_bits;
    end

endmodule

// File: rtl/chip_drop_animator.sv
// Falling-chip animation sequencer for the Connect Four board.
// Accepts a drop request, finds the landing row, walks anim_row down from the
// top row paced by frame_tick, rests at the landing row, then pulses commit.
// Optional macro DROP_BOUNCE_EN adds a one-row bounce before settling (L<5).
//   vga_clock, reset_n (sync, active-low)
//   frame_tick                         : per-frame pacing pulse
//   drop_req/drop_col/drop_player      : drop request, taken while drop_ready
//   color_p0/color_p1                  : board occupancy per player
//   drop_ready/drop_reject             : handshake status
//   anim_active/anim_col/anim_row/anim_player : display overlay
//   commit_valid/commit_col/commit_row/commit_player : board write pulse
module chip_drop_animator
    import connect4_pkg::*;
#(
    parameter int unsigned FRAMES_PER_ROW = 4,
    parameter int unsigned SETTLE_FRAMES  = 8
) (
    input  logic             vga_clock,
    input  logic             reset_n,
    input  logic             frame_tick,
    input  logic             drop_req,
    input  logic [COL_W-1:0] drop_col,
    input  logic             drop_player,
    input  logic [CELLS-1:0] color_p0,
    input  logic [CELLS-1:0] color_p1,
    output logic             drop_ready,
    output logic             drop_reject,
    output logic             anim_active,
    output logic [COL_W-1:0] anim_col,
    output logic [ROW_W-1:0] anim_row,
    output logic             anim_player,
    output logic             commit_valid,
    output logic [COL_W-1:0] commit_col,
    output logic [ROW_W-1:0] commit_row,
    output logic             commit_player
);

    localparam logic [CNT_W-1:0] FALL_LAST   = CNT_W'(FRAMES_PER_ROW - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_FRAMES - 1);
    localparam logic [ROW_W-1:0] TOP_ROW     = ROW_W'(ROWS - 1);

    drop_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             player_q, player_d;
    logic [ROW_W-1:0] land_q, land_d;
    logic             drop_ready_q, drop_ready_d;
    logic             drop_reject_q, drop_reject_d;
    logic             anim_active_q, anim_active_d;
    logic [COL_W-1:0] anim_col_q, anim_col_d;
    logic [ROW_W-1:0] anim_row_q, anim_row_d;
    logic             anim_player_q, anim_player_d;
    logic             commit_valid_q, commit_valid_d;
    logic [COL_W-1:0] commit_col_q, commit_col_d;
    logic [ROW_W-1:0] commit_row_q, commit_row_d;
    logic             commit_player_q, commit_player_d;

    logic [ROW_W-1:0] land_row;
    logic             col_full;

    landing_row_finder u_finder (
        .occupancy_i (color_p0 | color_p1),
        .col_i       (col_q),
        .land_row_o  (land_row),
        .full_o      (col_full)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        col_d           = col_q;
        player_d        = player_q;
        land_d          = land_q;
        drop_reject_d   = 1'b0;
        anim_active_d   = anim_active_q;
        anim_col_d      = anim_col_q;
        anim_row_d      = anim_row_q;
        anim_player_d   = anim_player_q;
        commit_valid_d  = 1'b0;
        commit_col_d    = commit_col_q;
        commit_row_d    = commit_row_q;
        commit_player_d = commit_player_q;

        case (state_q)
            ST_IDLE: begin
                if (drop_req) begin
                    col_d    = drop_col;
                    player_d = drop_player;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (col_full) begin
                    drop_reject_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    anim_active_d = 1'b1;
                    anim_row_d    = TOP_ROW;
                    anim_col_d    = col_q;
                    anim_player_d = player_q;
                    land_d        = land_row;
                    cnt_d         = '0;
                    state_d       = ST_FALL;
                end
            end
            ST_FALL: begin
                if (frame_tick) begin
                    if (cnt_q == FALL_LAST) begin
                        cnt_d = '0;
                        if (anim_row_q > land_q) begin
                            anim_row_d = anim_row_q - ROW_W'(1);
                        end else begin
`ifdef DROP_BOUNCE_EN
                            if (land_q < TOP_ROW) begin
                                anim_row_d = land_q + ROW_W'(1);
                                state_d    = ST_BOUNCE;
                            end else begin
                                state_d = ST_SETTLE;
                            end
`else
                            state_d = ST_SETTLE;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef DROP_BOUNCE_EN
            ST_BOUNCE: begin
                if (frame_tick) begin
                    if (cnt_q == FALL_LAST) begin
                        cnt_d      = '0;
                        anim_row_d = land_q;
                        state_d    = ST_SETTLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`endif
            ST_SETTLE: begin
                if (frame_tick) begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d           = '0;
                        commit_valid_d  = 1'b1;
                        commit_col_d    = col_q;
                        commit_row_d    = land_q;
                        commit_player_d = player_q;
                        state_d         = ST_COMMIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_COMMIT: begin
                // Overlay stays up through the commit cycle, drops on IDLE entry.
                anim_active_d = 1'b0;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        drop_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge vga_clock) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            col_q           <= '0;
            player_q        <= 1'b0;
            land_q          <= '0;
            drop_ready_q    <= 1'b1;
            drop_reject_q   <= 1'b0;
            anim_active_q   <= 1'b0;
            anim_col_q      <= '0;
            anim_row_q      <= '0;
            anim_player_q   <= 1'b0;
            commit_valid_q  <= 1'b0;
            commit_col_q    <= '0;
            commit_row_q    <= '0;
            commit_player_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            col_q           <= col_d;
            player_q        <= player_d;
            land_q          <= land_d;
            drop_ready_q    <= drop_ready_d;
            drop_reject_q   <= drop_reject_d;
            anim_active_q   <= anim_active_d;
            anim_col_q      <= anim_col_d;
            anim_row_q      <= anim_row_d;
            anim_player_q   <= anim_player_d;
            commit_valid_q  <= commit_valid_d;
            commit_col_q    <= commit_col_d;
            commit_row_q    <= commit_row_d;
            commit_player_q <= commit_player_d;
        end
    end

    assign drop_ready    = drop_ready_q;
    assign drop_reject   = drop_reject_q;
    assign anim_active   = anim_active_q;
    assign anim_col      = anim_col_q;
    assign anim_row      = anim_row_q;
    assign anim_player   = anim_player_q;
    assign commit_valid  = commit_valid_q;
    assign commit_col    = commit_col_q;
    assign commit_row    = commit_row_q;
    assign commit_player = commit_player_q;

endmodule

// File: tb/tb_chip_drop_animator.sv
// Directed self-checking bench for chip_drop_animator.
// Expected animation rows, tick counts and commit fields come from the
// board rules (row 0 at the bottom, FRAMES_PER_ROW per row, SETTLE_FRAMES rest).
module tb_chip_drop_animator;

    localparam int FPR = 4;
    localparam int SF  = 8;
`ifdef DROP_BOUNCE_EN
    localparam bit BOUNCE_ON = 1'b1;
`else
    localparam bit BOUNCE_ON = 1'b0;
`endif

    logic        vga_clock   = 1'b0;
    logic        reset_n     = 1'b0;
    logic        frame_tick  = 1'b0;
    logic        drop_req    = 1'b0;
    logic [2:0]  drop_col    = 3'd0;
    logic        drop_player = 1'b0;
    logic [41:0] color_p0    = '0;
    logic [41:0] color_p1    = '0;
    logic        drop_ready;
    logic        drop_reject;
    logic        anim_active;
    logic [2:0]  anim_col;
    logic [2:0]  anim_row;
    logic        anim_player;
    logic        commit_valid;
    logic [2:0]  commit_col;
    logic [2:0]  commit_row;
    logic        commit_player;

    int checks     = 0;
    int failures   = 0;
    int commit_cnt = 0;

    chip_drop_animator #(
        .FRAMES_PER_ROW (FPR),
        .SETTLE_FRAMES  (SF)
    ) dut (
        .vga_clock     (vga_clock),
        .reset_n       (reset_n),
        .frame_tick    (frame_tick),
        .drop_req      (drop_req),
        .drop_col      (drop_col),
        .drop_player   (drop_player),
        .color_p0      (color_p0),
        .color_p1      (color_p1),
        .drop_ready    (drop_ready),
        .drop_reject   (drop_reject),
        .anim_active   (anim_active),
        .anim_col      (anim_col),
        .anim_row      (anim_row),
        .anim_player   (anim_player),
        .commit_valid  (commit_valid),
        .commit_col    (commit_col),
        .commit_row    (commit_row),
        .commit_player (commit_player)
    );

    always #5 vga_clock = ~vga_clock;

    // Every cycle with commit_valid high is one board write.
    always @(negedge vga_clock) begin
        if (commit_valid) commit_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge vga_clock);
        #1;
    endtask

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_ready"},      drop_ready,    1);
        check_eq({pfx, "_reject"},     drop_reject,   0);
        check_eq({pfx, "_active"},     anim_active,   0);
        check_eq({pfx, "_anim_col"},   anim_col,      0);
        check_eq({pfx, "_anim_row"},   anim_row,      0);
        check_eq({pfx, "_anim_pl"},    anim_player,   0);
        check_eq({pfx, "_cvalid"},     commit_valid,  0);
        check_eq({pfx, "_ccol"},       commit_col,    0);
        check_eq({pfx, "_crow"},       commit_row,    0);
        check_eq({pfx, "_cplayer"},    commit_player, 0);
    endtask

    // Drop a chip expected to land on row lr; optionally inject a stray request
    // mid-fall or pull reset at tick index abort_at.
    task automatic run_drop(input int col, input bit pl, input int lr,
                            input int abort_at, input bit inject);
        bit bounce;
        int fall_ticks;
        int total;
        int c0;
        int exp_row;
        bounce     = BOUNCE_ON && (lr < 5);
        fall_ticks = (6 - lr) * FPR;
        total      = fall_ticks + (bounce ? FPR : 0) + SF;
        c0         = commit_cnt;

        drop_req    = 1'b1;
        drop_col    = 3'(col);
        drop_player = pl;
        step();
        drop_req = 1'b0;
        check_eq("check_not_ready", drop_ready, 0);
        check_eq("check_no_overlay", anim_active, 0);
        step();
        check_eq("start_active", anim_active, 1);
        check_eq("start_col",    anim_col,    col);
        check_eq("start_player", anim_player, pl);
        check_eq("start_reject", drop_reject, 0);

        for (int i = 0; i < total; i++) begin
            if (i < fall_ticks)                  exp_row = 5 - i / FPR;
            else if (bounce && i < fall_ticks + FPR) exp_row = lr + 1;
            else                                 exp_row = lr;
            check_eq("anim_row", anim_row, exp_row);
            if (i == abort_at) begin
                reset_n = 1'b0;
                step();
                check_reset_vals("abort");
                reset_n = 1'b1;
                check_eq("abort_no_commit", commit_cnt, c0);
                step();
                check_eq("abort_ready", drop_ready, 1);
                check_eq("abort_no_commit_after", commit_cnt, c0);
                return;
            end
            if (inject && i == 5) begin
                drop_req    = 1'b1;
                drop_col    = 3'd0;
                drop_player = ~pl;
            end
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            drop_req   = 1'b0;
            if (i != total - 1) begin
                if (i == 0) check_eq("commit_early", commit_valid, 0);
                step();
            end
        end

        check_eq("commit_valid",  commit_valid,  1);
        check_eq("commit_row",    commit_row,    lr);
        check_eq("commit_col",    commit_col,    col);
        check_eq("commit_player", commit_player, pl);
        check_eq("commit_overlay", anim_active,  1);
        check_eq("commit_not_ready", drop_ready, 0);
        step();
        check_eq("post_cvalid", commit_valid, 0);
        check_eq("post_active", anim_active,  0);
        check_eq("post_ready",  drop_ready,   1);
        check_eq("commit_count", commit_cnt,  c0 + 1);

        if (pl) color_p1[lr * 7 + col] = 1'b1;
        else    color_p0[lr * 7 + col] = 1'b1;
    endtask

    task automatic run_reject(input int col, input string tag);
        int c0;
        c0          = commit_cnt;
        drop_req    = 1'b1;
        drop_col    = 3'(col);
        drop_player = 1'b1;
        step();
        drop_req = 1'b0;
        check_eq({tag, "_chk_reject"}, drop_reject, 0);
        step();
        check_eq({tag, "_reject"}, drop_reject, 1);
        check_eq({tag, "_active"}, anim_active, 0);
        step();
        check_eq({tag, "_reject_gone"}, drop_reject, 0);
        check_eq({tag, "_ready"},       drop_ready,  1);
        check_eq({tag, "_active2"},     anim_active, 0);
        check_eq({tag, "_no_commit"},   commit_cnt,  c0);
    endtask

    initial begin
        reset_n = 1'b0;
        step();
        step();
        check_reset_vals("rst");
        reset_n = 1'b1;
        step();
        check_reset_vals("rst_rel");

        // Empty board, column 3, red: lands on row 0.
        run_drop(3, 1'b0, 0, -1, 1'b0);

        // Column 6 with rows 0-4 filled: lands on top row, never bounces.
        for (int r = 0; r < 5; r++) begin
            if (r % 2 == 0) color_p0[r * 7 + 6] = 1'b1;
            else            color_p1[r * 7 + 6] = 1'b1;
        end
        run_drop(6, 1'b1, 5, -1, 1'b0);

        // Full column and out-of-range column are both rejected.
        for (int r = 0; r < 6; r++) color_p0[r * 7 + 2] = 1'b1;
        run_reject(2, "full_col");
        run_reject(7, "bad_col");

        // Stray request during the fall must be ignored.
        run_drop(4, 1'b1, 0, -1, 1'b1);

        // Reset during SETTLE: no commit, outputs back to reset values.
        run_drop(0, 1'b0, 0, 6 * FPR + 3, 1'b0);

        // Stack on column 3: lands on row 1.
        run_drop(3, 1'b1, 1, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
